wb_daq_multichannel_dma: RTL and testbench
==========================================

// Module: wb_daq_multichannel_dma
// PURPOSE
//  N-channel DAQ capture engine. Accepts per-channel ADC samples (already in wb_clk domain),
//  buffers each channel in a small FIFO, round-robin arbitrates the channels and writes
//  32-bit words over a Wishbone B3 classic master into per-channel ring buffers in memory.
//  Replaces the single-channel channel/bus-master pair; slave registers drive the cfg_* ports.
// PARAMETERS
//  NUM_CH     4   number of channels (1..8)
//  ADC_DW     8   sample width (<=32; must be 8 when WB_DAQ_PACK_EN is defined)
//  AW         32  master address width
//  FIFO_LOG2  2   per-channel FIFO depth = 2**FIFO_LOG2 words
//  BUF_LOG2   8   ring buffer depth per channel = 2**BUF_LOG2 words
// PORTS
//  wb_clk           in   1            sole clock
//  wb_rst_n         in   1            asynchronous, active-low reset
//  sample_valid     in   NUM_CH       1-cycle strobe per channel
//  sample_data      in   NUM_CH*ADC_DW  channel c at [c*ADC_DW +: ADC_DW]
//  cfg_enable       in   NUM_CH       per-channel capture enable
//  cfg_base_addr    in   AW           ring region base, word aligned
//  cfg_clear        in   1            1-cycle: clears sticky flags, wptrs, FIFOs
//  wb_adr_o         out  AW           write address
//  wb_dat_o         out  32           write data
//  wb_sel_o/we_o    out  4/1          always 4'hF / 1 during cycles
//  wb_cyc_o/stb_o   out  1/1          cycle / strobe
//  wb_cti_o/bte_o   out  3/2          constant 3'b000 / 2'b00
//  wb_ack_i/err_i/rty_i in 1 each     slave responses
//  wptr             out  NUM_CH*BUF_LOG2  per-channel next ring write index
//  ovf_flag         out  NUM_CH       sticky: FIFO overflow (sample dropped)
//  irq_status       out  NUM_CH       sticky: half-buffer or wrap reached
//  bus_err          out  1            sticky: err_i seen
//  interrupt        out  1            |irq_status | bus_err
// BEHAVIOUR
//  - Reset: all outputs 0, FIFOs empty, wptrs 0, arbiter pointer = channel NUM_CH-1.
//  - Push: sample_valid[c] & cfg_enable[c] -> word (zero-extended sample) pushed; FIFO full -> drop, ovf_flag[c]<=1.
//  - FSM IDLE->ARB->WRITE->IDLE. IDLE: go ARB if any FIFO non-empty. ARB (1 cycle): grant first
//    non-empty channel searching upward from last grant+1 (mod NUM_CH); register address/data.
//  - WRITE: cyc/stb high, adr = base + ((c<<BUF_LOG2)+wptr[c])<<2; held stable until ack/err/rty.
//    ack: pop FIFO, wptr[c]++ (wraps 2**BUF_LOG2-1 -> 0), deassert cyc/stb next cycle.
//    err: pop, wptr advances, bus_err<=1. rty: drop cyc/stb 1 cycle, re-issue same word.
//  - Min 3 cycles per word (ARB, WRITE, IDLE) with zero-wait ack.
//  - irq_status[c]<=1 when wptr[c] advances to 2**(BUF_LOG2-1) or wraps to 0.
//  - Same-cycle push and pop on one FIFO: both happen, occupancy unchanged, even if full.
//  - cfg_enable[c] cleared: new samples ignored; queued words still drained.
//  - cfg_clear: flags, wptrs, FIFOs cleared; if in WRITE, current cycle completes, result discarded
//    (no pop, no wptr update). cfg_clear wins over same-cycle set of any flag.
//  - Reset mid-cycle drops cyc/stb asynchronously.
// CONFIGURATION
//  WB_DAQ_PACK_EN defined: four consecutive samples packed into one word, first sample in
//    bits[7:0]; word pushed on 4th sample; clearing cfg_enable[c] or cfg_clear discards partial word.
//  Not defined: one sample per word, zero-extended to 32 bits.
// TESTING
//  1 reset -> all outputs 0; one sample 8'hA5 ch0, base 32'h1000 -> write adr 32'h1000 dat 32'h0000_00A5.
//  2 ch0..3 all valid same cycle -> grant order 0,1,2,3; adr 1000,1400,1800,1C00 (BUF_LOG2=8).
//  3 hold ack low, 5 samples on ch1 -> 4 queued, ovf_flag[1]=1; after release 4 writes only.
//  4 256 words on ch2 -> irq_status[2] at word 128, wptr wraps to 0, adr back to 32'h1800.
//  5 rty on first attempt then ack -> same adr/dat re-issued, single wptr increment; err -> bus_err=1.
//  6 PACK_EN: samples 11,22,33,44 ch0 -> one write dat 32'h4433_2211.

Source files
------------

// File: rtl/wb_daq_multichannel_dma_if.sv
// Wishbone B3 classic bus bundle between the DAQ DMA write master and memory.
interface wb_daq_multichannel_dma_if #(
   parameter int AW = 32
);
   logic [AW-1:0] wb_adr_o;
   logic [31:0]   wb_dat_o;
   logic [3:0]    wb_sel_o;
   logic          wb_we_o;
   logic          wb_cyc_o;
   logic          wb_stb_o;
   logic [2:0]    wb_cti_o;
   logic [1:0]    wb_bte_o;
   logic          wb_ack_i;
   logic          wb_err_i;
   logic          wb_rty_i;

   modport master (
      output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
      input  wb_ack_i, wb_err_i, wb_rty_i
   );

   modport slave (
      input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
      output wb_ack_i, wb_err_i, wb_rty_i
   );
endinterface

// File: rtl/wb_daq_multichannel_dma.sv
// N-channel DAQ capture: per-channel FIFOs, round-robin arbiter, Wishbone writes into ring buffers.
// Optional WB_DAQ_PACK_EN packs four 8-bit samples per 32-bit word (first sample in bits [7:0]).
module wb_daq_multichannel_dma #(
   parameter int NUM_CH    = 4,
   parameter int ADC_DW    = 8,
   parameter int AW        = 32,
   parameter int FIFO_LOG2 = 2,
   parameter int BUF_LOG2  = 8
) (
   input  logic                       wb_clk,
   input  logic                       wb_rst_n,
   input  logic [NUM_CH-1:0]          sample_valid,
   input  logic [NUM_CH*ADC_DW-1:0]   sample_data,
   input  logic [NUM_CH-1:0]          cfg_enable,
   input  logic [AW-1:0]              cfg_base_addr,
   input  logic                       cfg_clear,
   wb_daq_multichannel_dma_if.master  wb,
   output logic [NUM_CH*BUF_LOG2-1:0] wptr,
   output logic [NUM_CH-1:0]          ovf_flag,
   output logic [NUM_CH-1:0]          irq_status,
   output logic                       bus_err,
   output logic                       interrupt
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [FIFO_LOG2:0]   CNT_ONE  = (FIFO_LOG2+1)'(1);
   localparam logic [FIFO_LOG2:0]   CNT_FULL = CNT_ONE << FIFO_LOG2;
   localparam logic [FIFO_LOG2-1:0] PTR_ONE  = FIFO_LOG2'(1);
   localparam logic [BUF_LOG2-1:0]  WP_ONE   = BUF_LOG2'(1);
   localparam logic [BUF_LOG2-1:0]  WP_HALF  = WP_ONE << (BUF_LOG2-1);

   typedef enum logic [1:0] {S_IDLE, S_ARB, S_WRITE, S_RETRY} state_t;

   state_t               state_q, state_d;
   logic [CH_W-1:0]      gnt_q, gnt_d;
   logic [AW-1:0]        adr_q, adr_d;
   logic [31:0]          dat_q, dat_d;
   logic                 discard_q, discard_d;
   logic                 bus_err_q, bus_err_d;
   logic [NUM_CH-1:0]    ovf_q, ovf_d;
   logic [NUM_CH-1:0]    irq_q, irq_d;
   logic [FIFO_LOG2-1:0] rd_ptr_q [NUM_CH];
   logic [FIFO_LOG2-1:0] rd_ptr_d [NUM_CH];
   logic [FIFO_LOG2-1:0] wr_ptr_q [NUM_CH];
   logic [FIFO_LOG2-1:0] wr_ptr_d [NUM_CH];
   logic [FIFO_LOG2:0]   cnt_q    [NUM_CH];
   logic [FIFO_LOG2:0]   cnt_d    [NUM_CH];
   logic [BUF_LOG2-1:0]  wptr_q   [NUM_CH];
   logic [BUF_LOG2-1:0]  wptr_d   [NUM_CH];
   logic [31:0]          fifo_mem [NUM_CH][2**FIFO_LOG2];

   logic [NUM_CH-1:0]    push, do_push, full, pop, not_empty;
   logic [31:0]          push_word [NUM_CH];
   logic                 commit, resp_ack, resp_err, resp_rty, end_cycle;
   logic [CH_W:0]        pick;
   logic [BUF_LOG2-1:0]  wp_next;

   function automatic logic [31:0] zext(input logic [ADC_DW-1:0] s);
      return 32'(s);
   endfunction

   // Returns {found, channel}: first non-empty channel after 'last', wrapping modulo NUM_CH.
   function automatic logic [CH_W:0] arb_pick(input logic [CH_W-1:0] last,
                                              input logic [NUM_CH-1:0] ne);
      logic [CH_W:0] r;
      int idx;
      r = '0;
      for (int i = NUM_CH; i >= 1; i--) begin
         idx = int'(last) + i;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (ne[CH_W'(idx)]) r = {1'b1, CH_W'(idx)};
      end
      return r;
   endfunction

`ifdef WB_DAQ_PACK_EN
   logic [23:0] pack_q     [NUM_CH];
   logic [23:0] pack_d     [NUM_CH];
   logic [1:0]  pack_cnt_q [NUM_CH];
   logic [1:0]  pack_cnt_d [NUM_CH];

   always_comb begin
      push = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         pack_d[c]     = pack_q[c];
         pack_cnt_d[c] = pack_cnt_q[c];
         push_word[c]  = {sample_data[c*ADC_DW +: 8], pack_q[c]};
         // A disabled channel or a clear throws away any partially assembled word.
         if (cfg_clear || !cfg_enable[c]) begin
            pack_cnt_d[c] = 2'd0;
         end else if (sample_valid[c]) begin
            if (pack_cnt_q[c] == 2'd3) begin
               push[c]       = 1'b1;
               pack_cnt_d[c] = 2'd0;
            end else begin
               pack_d[c][{pack_cnt_q[c], 3'b000} +: 8] = sample_data[c*ADC_DW +: 8];
               pack_cnt_d[c] = pack_cnt_q[c] + 2'd1;
            end
         end
      end
   end

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         for (int c = 0; c < NUM_CH; c++) pack_cnt_q[c] <= 2'd0;
      end else begin
         pack_cnt_q <= pack_cnt_d;
      end
   end

   always_ff @(posedge wb_clk) begin
      pack_q <= pack_d;
   end
`else
   always_comb begin
      push = sample_valid & cfg_enable;
      for (int c = 0; c < NUM_CH; c++) push_word[c] = zext(sample_data[c*ADC_DW +: ADC_DW]);
   end
`endif

   always_comb begin
      not_empty = '0;
      for (int c = 0; c < NUM_CH; c++) not_empty[c] = (cnt_q[c] != '0);
   end

   assign pick     = arb_pick(gnt_q, not_empty);
   assign resp_ack = wb.wb_ack_i;
   assign resp_err = wb.wb_err_i;
   assign resp_rty = wb.wb_rty_i;

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      discard_d = discard_q;
      commit    = 1'b0;
      end_cycle = discard_q || cfg_clear;
      pop       = '0;
      case (state_q)
         S_IDLE: if (|not_empty && !cfg_clear) state_d = S_ARB;
         S_ARB: begin
            if (pick[CH_W] && !cfg_clear) begin
               gnt_d     = pick[CH_W-1:0];
               adr_d     = cfg_base_addr + (AW'({pick[CH_W-1:0], wptr_q[pick[CH_W-1:0]]}) << 2);
               dat_d     = fifo_mem[pick[CH_W-1:0]][rd_ptr_q[pick[CH_W-1:0]]];
               discard_d = 1'b0;
               state_d   = S_WRITE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WRITE: begin
            if (cfg_clear) discard_d = 1'b1;
            if (resp_ack || resp_err) begin
               commit    = !end_cycle;
               discard_d = 1'b0;
               state_d   = S_IDLE;
            end else if (resp_rty) begin
               discard_d = 1'b0;
               state_d   = end_cycle ? S_IDLE : S_RETRY;
            end
         end
         S_RETRY: begin
            discard_d = 1'b0;
            state_d   = end_cycle ? S_IDLE : S_WRITE;
         end
         default: state_d = S_IDLE;
      endcase
      if (commit) pop[gnt_q] = 1'b1;
   end

   // FIFO bookkeeping: a pop frees a slot in the same cycle, so push into a full FIFO survives.
   always_comb begin
      full    = '0;
      do_push = '0;
      ovf_d   = ovf_q;
      for (int c = 0; c < NUM_CH; c++) begin
         full[c]     = (cnt_q[c] == CNT_FULL);
         do_push[c]  = push[c] && (!full[c] || pop[c]) && !cfg_clear;
         rd_ptr_d[c] = rd_ptr_q[c];
         wr_ptr_d[c] = wr_ptr_q[c];
         cnt_d[c]    = cnt_q[c];
         if (cfg_clear) begin
            rd_ptr_d[c] = '0;
            wr_ptr_d[c] = '0;
            cnt_d[c]    = '0;
            ovf_d[c]    = 1'b0;
         end else begin
            if (do_push[c]) wr_ptr_d[c] = wr_ptr_q[c] + PTR_ONE;
            if (pop[c])     rd_ptr_d[c] = rd_ptr_q[c] + PTR_ONE;
            if (do_push[c] && !pop[c])      cnt_d[c] = cnt_q[c] + CNT_ONE;
            else if (!do_push[c] && pop[c]) cnt_d[c] = cnt_q[c] - CNT_ONE;
            if (push[c] && full[c] && !pop[c]) ovf_d[c] = 1'b1;
         end
      end
   end

   always_comb begin
      wptr_d    = wptr_q;
      irq_d     = irq_q;
      bus_err_d = bus_err_q;
      wp_next   = wptr_q[gnt_q] + WP_ONE;
      if (cfg_clear) begin
         for (int c = 0; c < NUM_CH; c++) wptr_d[c] = '0;
         irq_d     = '0;
         bus_err_d = 1'b0;
      end else if (commit) begin
         wptr_d[gnt_q] = wp_next;
         if (wp_next == WP_HALF || wp_next == '0) irq_d[gnt_q] = 1'b1;
         if (resp_err && !resp_ack) bus_err_d = 1'b1;
      end
   end

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q   <= S_IDLE;
         gnt_q     <= CH_W'(NUM_CH-1);
         adr_q     <= '0;
         dat_q     <= '0;
         discard_q <= 1'b0;
         bus_err_q <= 1'b0;
         ovf_q     <= '0;
         irq_q     <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            rd_ptr_q[c] <= '0;
            wr_ptr_q[c] <= '0;
            cnt_q[c]    <= '0;
            wptr_q[c]   <= '0;
         end
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         discard_q <= discard_d;
         bus_err_q <= bus_err_d;
         ovf_q     <= ovf_d;
         irq_q     <= irq_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         cnt_q     <= cnt_d;
         wptr_q    <= wptr_d;
      end
   end

   always_ff @(posedge wb_clk) begin
      for (int c = 0; c < NUM_CH; c++)
         if (do_push[c]) fifo_mem[c][wr_ptr_q[c]] <= push_word[c];
   end

   // Cycle/strobe decode straight from the state flop so reset drops them immediately.
   assign wb.wb_cyc_o = (state_q == S_WRITE);
   assign wb.wb_stb_o = (state_q == S_WRITE);
   assign wb.wb_we_o  = (state_q == S_WRITE);
   assign wb.wb_sel_o = {4{state_q == S_WRITE}};
   assign wb.wb_adr_o = adr_q;
   assign wb.wb_dat_o = dat_q;
   assign wb.wb_cti_o = 3'b000;
   assign wb.wb_bte_o = 2'b00;

   always_comb begin
      wptr = '0;
      for (int c = 0; c < NUM_CH; c++) wptr[c*BUF_LOG2 +: BUF_LOG2] = wptr_q[c];
   end

   assign ovf_flag   = ovf_q;
   assign irq_status = irq_q;
   assign bus_err    = bus_err_q;
   assign interrupt  = (|irq_q) | bus_err_q;
endmodule

// File: tb/tb_wb_daq_multichannel_dma.sv
// Directed bench for wb_daq_multichannel_dma: reset, arbitration, overflow, wrap, retry/error, clear.
module tb_wb_daq_multichannel_dma;
   localparam int NUM_CH = 4, ADC_DW = 8, AW = 32, FIFO_LOG2 = 2, BUF_LOG2 = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  sample_valid = '0;
   logic [31:0] sample_data = '0;
   logic [3:0]  cfg_enable = '1;
   logic [31:0] cfg_base_addr = 32'h1000;
   logic        cfg_clear = 1'b0;
   logic [31:0] wptr;
   logic [3:0]  ovf_flag, irq_status;
   logic        bus_err, interrupt;

   logic        ack_en = 1'b1;
   logic        err_en = 1'b0;
   int          rty_limit = 0;
   int          rty_count = 0;
   int          err_count = 0;
   int          log_n = 0;
   logic [31:0] log_adr [0:1023];
   logic [31:0] log_dat [0:1023];
   logic [31:0] rty_adr = '0;
   logic [31:0] rty_dat = '0;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   wb_daq_multichannel_dma_if #(.AW(AW)) bus ();

   wb_daq_multichannel_dma #(
      .NUM_CH(NUM_CH), .ADC_DW(ADC_DW), .AW(AW), .FIFO_LOG2(FIFO_LOG2), .BUF_LOG2(BUF_LOG2)
   ) dut (
      .wb_clk(clk), .wb_rst_n(rst_n), .sample_valid(sample_valid), .sample_data(sample_data),
      .cfg_enable(cfg_enable), .cfg_base_addr(cfg_base_addr), .cfg_clear(cfg_clear), .wb(bus),
      .wptr(wptr), .ovf_flag(ovf_flag), .irq_status(irq_status), .bus_err(bus_err),
      .interrupt(interrupt)
   );

   // Zero-wait memory slave: retry while below rty_limit, else error or ack.
   assign bus.wb_rty_i = bus.wb_cyc_o & bus.wb_stb_o & (rty_count < rty_limit);
   assign bus.wb_err_i = bus.wb_cyc_o & bus.wb_stb_o & err_en & !bus.wb_rty_i;
   assign bus.wb_ack_i = bus.wb_cyc_o & bus.wb_stb_o & ack_en & !err_en & !bus.wb_rty_i;

   always @(posedge clk) begin
      if (bus.wb_cyc_o && bus.wb_stb_o && bus.wb_ack_i && log_n < 1024) begin
         log_adr[log_n] <= bus.wb_adr_o;
         log_dat[log_n] <= bus.wb_dat_o;
         log_n <= log_n + 1;
      end
      if (bus.wb_cyc_o && bus.wb_stb_o && bus.wb_rty_i) begin
         rty_count <= rty_count + 1;
         rty_adr <= bus.wb_adr_o;
         rty_dat <= bus.wb_dat_o;
      end
      if (bus.wb_cyc_o && bus.wb_stb_o && bus.wb_err_i) err_count <= err_count + 1;
   end

   task automatic do_reset();
      rst_n = 1'b0;
      sample_valid = '0;
      sample_data = '0;
      cfg_clear = 1'b0;
      cfg_enable = '1;
      cfg_base_addr = 32'h1000;
      ack_en = 1'b1;
      err_en = 1'b0;
      rty_limit = rty_count;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic send(input int ch, input logic [7:0] d);
      @(negedge clk);
      sample_valid[ch] = 1'b1;
      sample_data[ch*8 +: 8] = d;
      @(negedge clk);
      sample_valid = '0;
   endtask

   task automatic wait_writes(input int target, input string name);
      for (int i = 0; i < 200 && log_n < target; i++) @(negedge clk);
      checks++;
      if (log_n < target) begin
         errors++;
         $display("FAIL %s timeout: writes=%0d required=%0d", name, log_n, target);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o} !== 7'd0) begin
         errors++;
         $display("FAIL reset_ctl: got %b required 0", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o});
      end
      checks++;
      if ({bus.wb_adr_o, bus.wb_dat_o, bus.wb_cti_o, bus.wb_bte_o} !== 69'd0) begin
         errors++;
         $display("FAIL reset_bus: adr=%h dat=%h required 0", bus.wb_adr_o, bus.wb_dat_o);
      end
      checks++;
      if ({wptr, ovf_flag, irq_status, bus_err, interrupt} !== 42'd0) begin
         errors++;
         $display("FAIL reset_status: wptr=%h ovf=%b irq=%b err=%b int=%b required 0",
                  wptr, ovf_flag, irq_status, bus_err, interrupt);
      end
      do_reset();
   endtask

   task automatic test_single();
      int n0;
      do_reset();
      n0 = log_n;
      send(0, 8'hA5);
      wait_writes(n0 + 1, "single");
      checks++;
      if (log_adr[n0] !== 32'h1000) begin
         errors++; $display("FAIL single_adr: got %h required 00001000", log_adr[n0]);
      end
      checks++;
      if (log_dat[n0] !== 32'h0000_00A5) begin
         errors++; $display("FAIL single_dat: got %h required 000000a5", log_dat[n0]);
      end
      checks++;
      if (wptr[7:0] !== 8'd1) begin
         errors++; $display("FAIL single_wptr: got %0d required 1", wptr[7:0]);
      end
   endtask

   task automatic test_round_robin();
      int n0;
      logic [31:0] exp_adr [4];
      logic [31:0] exp_dat [4];
      exp_adr = '{32'h1000, 32'h1400, 32'h1800, 32'h1C00};
      exp_dat = '{32'h11, 32'h22, 32'h33, 32'h44};
      do_reset();
      n0 = log_n;
      @(negedge clk);
      sample_valid = 4'hF;
      sample_data = 32'h4433_2211;
      @(negedge clk);
      sample_valid = '0;
      wait_writes(n0 + 4, "round_robin");
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (log_adr[n0+k] !== exp_adr[k] || log_dat[n0+k] !== exp_dat[k]) begin
            errors++;
            $display("FAIL rr_word%0d: got adr=%h dat=%h required adr=%h dat=%h",
                     k, log_adr[n0+k], log_dat[n0+k], exp_adr[k], exp_dat[k]);
         end
      end
   endtask

   task automatic test_overflow();
      int n0;
      do_reset();
      n0 = log_n;
      ack_en = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         sample_valid[1] = 1'b1;
         sample_data[15:8] = 8'(i);
      end
      @(negedge clk);
      sample_valid = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (ovf_flag !== 4'b0010 || interrupt !== 1'b0) begin
         errors++; $display("FAIL ovf_flag: got ovf=%b int=%b required ovf=0010 int=0", ovf_flag, interrupt);
      end
      checks++;
      if (bus.wb_cyc_o !== 1'b1 || bus.wb_adr_o !== 32'h1400) begin
         errors++; $display("FAIL ovf_stall: got cyc=%b adr=%h required cyc=1 adr=00001400",
                            bus.wb_cyc_o, bus.wb_adr_o);
      end
      ack_en = 1'b1;
      wait_writes(n0 + 4, "ovf_drain");
      repeat (20) @(negedge clk);
      checks++;
      if (log_n !== n0 + 4) begin
         errors++; $display("FAIL ovf_count: got %0d writes required %0d", log_n - n0, 4);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (log_dat[n0+k] !== 32'(k + 1) || log_adr[n0+k] !== 32'h1400 + 32'(4*k)) begin
            errors++; $display("FAIL ovf_word%0d: got adr=%h dat=%h required adr=%h dat=%h",
                               k, log_adr[n0+k], log_dat[n0+k], 32'h1400 + 32'(4*k), k + 1);
         end
      end
   endtask

   task automatic test_wrap();
      int n0;
      do_reset();
      n0 = log_n;
      for (int i = 0; i < 256; i++) begin
         send(2, 8'(i));
         wait_writes(n0 + i + 1, "wrap_word");
         if (i == 126) begin
            checks++;
            if (irq_status[2] !== 1'b0) begin
               errors++; $display("FAIL wrap_irq_early: got %b required 0 after 127 words", irq_status[2]);
            end
         end
         if (i == 127) begin
            checks++;
            if (irq_status[2] !== 1'b1 || wptr[23:16] !== 8'd128) begin
               errors++; $display("FAIL wrap_irq_half: got irq=%b wptr=%0d required irq=1 wptr=128",
                                  irq_status[2], wptr[23:16]);
            end
         end
      end
      checks++;
      if (wptr[23:16] !== 8'd0 || log_adr[n0+255] !== 32'h1BFC || interrupt !== 1'b1) begin
         errors++; $display("FAIL wrap_end: got wptr=%0d adr=%h int=%b required wptr=0 adr=00001bfc int=1",
                            wptr[23:16], log_adr[n0+255], interrupt);
      end
      send(2, 8'h77);
      wait_writes(n0 + 257, "wrap_again");
      checks++;
      if (log_adr[n0+256] !== 32'h1800) begin
         errors++; $display("FAIL wrap_adr: got %h required 00001800", log_adr[n0+256]);
      end
      @(negedge clk);
      cfg_clear = 1'b1;
      @(negedge clk);
      cfg_clear = 1'b0;
      checks++;
      if (irq_status !== 4'd0 || wptr !== 32'd0 || interrupt !== 1'b0) begin
         errors++; $display("FAIL clear_flags: got irq=%b wptr=%h int=%b required 0", irq_status, wptr, interrupt);
      end
   endtask

   task automatic test_retry_err();
      int n0, r0, e0;
      do_reset();
      n0 = log_n;
      r0 = rty_count;
      rty_limit = rty_count + 1;
      send(3, 8'h5A);
      wait_writes(n0 + 1, "retry");
      checks++;
      if (rty_count !== r0 + 1 || rty_adr !== 32'h1C00 || rty_dat !== 32'h5A) begin
         errors++; $display("FAIL retry_attempt: got n=%0d adr=%h dat=%h required n=1 adr=00001c00 dat=0000005a",
                            rty_count - r0, rty_adr, rty_dat);
      end
      checks++;
      if (log_adr[n0] !== 32'h1C00 || log_dat[n0] !== 32'h5A || wptr[31:24] !== 8'd1) begin
         errors++; $display("FAIL retry_reissue: got adr=%h dat=%h wptr=%0d required 00001c00 0000005a 1",
                            log_adr[n0], log_dat[n0], wptr[31:24]);
      end
      checks++;
      if (bus_err !== 1'b0) begin
         errors++; $display("FAIL err_pre: got %b required 0", bus_err);
      end
      e0 = err_count;
      err_en = 1'b1;
      send(3, 8'h66);
      for (int i = 0; i < 50 && err_count == e0; i++) @(negedge clk);
      err_en = 1'b0;
      @(negedge clk);
      checks++;
      if (bus_err !== 1'b1 || interrupt !== 1'b1 || wptr[31:24] !== 8'd2) begin
         errors++; $display("FAIL err_resp: got err=%b int=%b wptr=%0d required 1 1 2",
                            bus_err, interrupt, wptr[31:24]);
      end
   endtask

   task automatic test_reset_midcycle();
      do_reset();
      ack_en = 1'b0;
      send(0, 8'h05);
      for (int i = 0; i < 50 && !bus.wb_cyc_o; i++) @(negedge clk);
      checks++;
      if (bus.wb_cyc_o !== 1'b1) begin
         errors++; $display("FAIL midrst_start: got cyc=%b required 1", bus.wb_cyc_o);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0) begin
         errors++; $display("FAIL midrst_drop: got cyc=%b stb=%b required 0 0", bus.wb_cyc_o, bus.wb_stb_o);
      end
      do_reset();
   endtask

   task automatic test_enable();
      int n0;
      do_reset();
      n0 = log_n;
      cfg_enable = 4'b1110;
      send(0, 8'h99);
      repeat (10) @(negedge clk);
      checks++;
      if (log_n !== n0) begin
         errors++; $display("FAIL enable_ignore: got %0d writes required 0", log_n - n0);
      end
      ack_en = 1'b0;
      send(1, 8'h12);
      cfg_enable = 4'b0000;
      send(1, 8'h34);
      repeat (3) @(negedge clk);
      ack_en = 1'b1;
      wait_writes(n0 + 1, "enable_drain");
      repeat (10) @(negedge clk);
      checks++;
      if (log_n !== n0 + 1 || log_dat[n0] !== 32'h12) begin
         errors++; $display("FAIL enable_drain: got n=%0d dat=%h required n=1 dat=00000012", log_n - n0, log_dat[n0]);
      end
      cfg_enable = 4'hF;
   endtask

   task automatic test_clear_discard();
      int n0;
      do_reset();
      n0 = log_n;
      ack_en = 1'b0;
      send(0, 8'h21);
      for (int i = 0; i < 50 && !bus.wb_cyc_o; i++) @(negedge clk);
      cfg_clear = 1'b1;
      @(negedge clk);
      cfg_clear = 1'b0;
      ack_en = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (log_n !== n0 + 1 || wptr[7:0] !== 8'd0) begin
         errors++; $display("FAIL clear_discard: got n=%0d wptr=%0d required n=1 wptr=0", log_n - n0, wptr[7:0]);
      end
   endtask

   task automatic test_word_format();
      int n0;
      do_reset();
      n0 = log_n;
`ifdef WB_DAQ_PACK_EN
      send(0, 8'h11);
      send(0, 8'h22);
      send(0, 8'h33);
      send(0, 8'h44);
      wait_writes(n0 + 1, "pack");
      checks++;
      if (log_dat[n0] !== 32'h4433_2211 || log_adr[n0] !== 32'h1000) begin
         errors++; $display("FAIL pack_word: got adr=%h dat=%h required 00001000 44332211", log_adr[n0], log_dat[n0]);
      end
`else
      send(0, 8'hFF);
      wait_writes(n0 + 1, "zext");
      checks++;
      if (log_dat[n0] !== 32'h0000_00FF || log_adr[n0] !== 32'h1000) begin
         errors++; $display("FAIL zext_word: got adr=%h dat=%h required 00001000 000000ff", log_adr[n0], log_dat[n0]);
      end
`endif
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
`ifdef WB_DAQ_PACK_EN
      test_word_format();
`else
      test_single();
      test_round_robin();
      test_overflow();
      test_wrap();
      test_retry_err();
      test_reset_midcycle();
      test_enable();
      test_clear_discard();
      test_word_format();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
